// File: rtl/regfile_debug_pkg.sv
// regfile_debug_pkg: state encodings, opcodes and register-count constants for regfile_debug
`ifndef REGFILE_DEBUG_PKG_SV
`define REGFILE_DEBUG_PKG_SV
package regfile_debug_pkg;
    localparam int RD_NUM_REGS = 32;
    localparam int RD_ADDR_W = $clog2(RD_NUM_REGS);
    localparam logic RD_OP_DUMP = 1'b0;
    localparam logic RD_OP_LOAD = 1'b1;
    typedef logic [RD_ADDR_W-1:0] rd_addr_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_DUMP_ADDR,
        ST_DUMP_CAP,
        ST_DUMP_TX,
        ST_LOAD_RX,
        ST_LOAD_WR,
        ST_RELEASE
    } rd_state_e;
endpackage
`endif

// File: rtl/regfile_debug_if.sv
// regfile_debug_if: command, halt, regfile and byte-stream signals of regfile_debug
interface regfile_debug_if;
    import regfile_debug_pkg::*;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    rd_addr_t    cmd_first;
    rd_addr_t    cmd_count_m1;
    logic        done;
    logic        halt_req;
    logic        halt_ack;
    logic [5:0]  rf_b;
    logic [7:0]  rf_Rb;
    logic        rf_write;
    logic        rf_write_word;
    logic [5:0]  rf_d;
    logic [15:0] rf_Rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    modport master (
        input  cmd_valid, cmd_op, cmd_first, cmd_count_m1, halt_ack, rf_Rb, tx_ready, rx_data, rx_valid,
        output cmd_ready, done, halt_req, rf_b, rf_write, rf_write_word, rf_d, rf_Rd, tx_data, tx_valid, rx_ready
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_first, cmd_count_m1, halt_ack, rf_Rb, tx_ready, rx_data, rx_valid,
        input  cmd_ready, done, halt_req, rf_b, rf_write, rf_write_word, rf_d, rf_Rd, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/regfile_debug.sv
// regfile_debug: halts the core, then dumps or loads a register range over byte streams.
// The load path exists only when REGFILE_DEBUG_LOAD_EN is defined.
module regfile_debug
    import regfile_debug_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    regfile_debug_if.master bus
);
    rd_state_e   state_q, state_d;
    rd_addr_t    addr_q, addr_d, rem_q, rem_d, addr_nx;
    logic        op_q, op_d, tx_valid_q, tx_valid_d, done_q, done_d;
    logic [5:0]  rf_b_q, rf_b_d, rf_d_q, rf_d_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] rf_rd_q, rf_rd_d;

    assign addr_nx = addr_q + rd_addr_t'(1);

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        rem_d = rem_q;
        op_d = op_q;
        rf_b_d = rf_b_q;
        tx_data_d = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d = 1'b0;
        rf_d_d = rf_d_q;
        rf_rd_d = rf_rd_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                addr_d = bus.cmd_first;
                rem_d = bus.cmd_count_m1;
                op_d = bus.cmd_op;
                state_d = ST_HALT;
            end
            ST_HALT: if (bus.halt_ack) begin
                // rf_b moves only once the core has handed over the regfile ports
                rf_b_d = op_q == RD_OP_DUMP ? {1'b0, addr_q} : rf_b_q;
`ifdef REGFILE_DEBUG_LOAD_EN
                state_d = op_q == RD_OP_LOAD ? ST_LOAD_RX : ST_DUMP_ADDR;
`else
                state_d = op_q == RD_OP_DUMP ? ST_DUMP_ADDR : ST_RELEASE;
`endif
            end
            ST_DUMP_ADDR: state_d = ST_DUMP_CAP;
            ST_DUMP_CAP: begin
                tx_data_d = bus.rf_Rb;
                tx_valid_d = 1'b1;
                state_d = ST_DUMP_TX;
            end
            ST_DUMP_TX: if (bus.tx_ready) begin
                tx_valid_d = 1'b0;
                state_d = rem_q == '0 ? ST_RELEASE : ST_DUMP_ADDR;
                addr_d = rem_q == '0 ? addr_q : addr_nx;
                rem_d = rem_q == '0 ? rem_q : rem_q - rd_addr_t'(1);
                rf_b_d = rem_q == '0 ? rf_b_q : {1'b0, addr_nx};
            end
`ifdef REGFILE_DEBUG_LOAD_EN
            ST_LOAD_RX: if (bus.rx_valid) begin
                rf_d_d = {1'b0, addr_q};
                rf_rd_d = {8'h00, bus.rx_data};
                state_d = ST_LOAD_WR;
            end
            ST_LOAD_WR: begin
                state_d = rem_q == '0 ? ST_RELEASE : ST_LOAD_RX;
                addr_d = rem_q == '0 ? addr_q : addr_nx;
                rem_d = rem_q == '0 ? rem_q : rem_q - rd_addr_t'(1);
            end
`endif
            ST_RELEASE: if (!bus.halt_ack) begin
                done_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            rem_q <= '0;
            op_q <= 1'b0;
            rf_b_q <= '0;
            tx_data_q <= '0;
            tx_valid_q <= 1'b0;
            done_q <= 1'b0;
            rf_d_q <= '0;
            rf_rd_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            rem_q <= rem_d;
            op_q <= op_d;
            rf_b_q <= rf_b_d;
            tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q <= done_d;
            rf_d_q <= rf_d_d;
            rf_rd_q <= rf_rd_d;
        end
    end

    assign bus.cmd_ready = state_q == ST_IDLE;
    assign bus.halt_req = !(state_q inside {ST_IDLE, ST_RELEASE});
    assign bus.done = done_q;
    assign bus.rf_b = rf_b_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.rf_d = rf_d_q;
    assign bus.rf_Rd = rf_rd_q;
    assign bus.rf_write_word = 1'b0;
`ifdef REGFILE_DEBUG_LOAD_EN
    assign bus.rx_ready = state_q == ST_LOAD_RX;
    assign bus.rf_write = state_q == ST_LOAD_WR && bus.halt_ack;
`else
    logic unused_rx;
    assign unused_rx = ^{bus.rx_data, bus.rx_valid};
    assign bus.rx_ready = 1'b0;
    assign bus.rf_write = 1'b0;
`endif
endmodule

// File: doc/regfile_debug.md
# regfile_debug

Debug-port initiator that drives the CPU register file's read and write ports while the core is halted. On a command it handshakes a halt with the core. It then either dumps a range of the 32 registers as a byte stream, or loads a range from an incoming byte stream. It sits between the debug transport (UART/SPI bridge) and the regfile port mux in the CPU top level.

## Interface
- No parameters. Register count fixed at 32; addresses 5 bits internally, 6 bits on regfile ports with bit 5 = 0.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = dump, 1 = load
- cmd_first  in  5  first register index
- cmd_count_m1  in  5  register count minus 1 (1..32 registers)
- done  out  1  one-cycle pulse when a command finishes
- halt_req  out  1  request core stall and release of regfile ports
- halt_ack  in  1  core stalled; regfile ports owned by this block
- rf_b  out  6  regfile byte read address
- rf_Rb  in  8  regfile byte read data, valid one cycle after rf_b
- rf_write, rf_write_word  out  1 each  write strobe; word flag always 0
- rf_d  out  6  write address
- rf_Rd  out  16  write data, {8'h00, byte}
- tx_data  out  8, tx_valid  out  1, tx_ready  in  1  dump stream
- rx_data  in  8, rx_valid  in  1, rx_ready  out  1  load stream

## Operation
- States: IDLE, HALT, DUMP_ADDR, DUMP_CAP, DUMP_TX, LOAD_RX, LOAD_WR, RELEASE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr=cmd_first and remaining=cmd_count_m1, then go to HALT.
- HALT: halt_req=1, wait for halt_ack=1. Then go to DUMP_ADDR (op 0) or LOAD_RX (op 1).
- DUMP_ADDR: drive rf_b=addr, then go to DUMP_CAP.
- DUMP_CAP: hold rf_b, register rf_Rb into tx_data, set tx_valid, then go to DUMP_TX.
- DUMP_TX: hold tx_data/tx_valid until tx_ready.
  - On the transfer, if remaining==0 go to RELEASE.
  - Otherwise addr+=1, remaining-=1, go to DUMP_ADDR.
- LOAD_RX: rx_ready=1. On rx_valid, latch the byte and go to LOAD_WR.
- LOAD_WR: one-cycle rf_write=1, rf_d=addr, rf_Rd={8'h00,byte}.
  - If remaining==0 go to RELEASE.
  - Otherwise increment/decrement as for dump, then go to LOAD_RX.
- RELEASE: halt_req=0. Wait for halt_ack=0, then pulse done and go to IDLE.
- Address arithmetic is 5-bit modulo 32: index 31+1 wraps to 0. Count 32 from any start covers every register exactly once.
- rf_write is only ever asserted while halt_ack=1 and halt_req=1.
- Reset in any state: return to IDLE next edge, abandoning any partial dump/load. Writes already issued stay written.

## Timing
- Reset values: cmd_ready=1 after reset deasserts. halt_req, done, tx_valid, rx_ready, rf_write, rf_write_word = 0. tx_data, rf_b, rf_d, rf_Rd = 0.
- Command accept to halt_req high: 1 cycle.
- Dump: 3 cycles per byte with tx_ready held high.
- Load: 2 cycles per byte with rx_valid held high.
- rf_b is stable from DUMP_ADDR through DUMP_CAP. The regfile's one-cycle read latency is absorbed by DUMP_CAP.
- Dump immediately after load reads back loaded values. Consecutive commands are separated by at least RELEASE + IDLE.
- tx_data must not change while tx_valid=1 and tx_ready=0.

## Configuration
- REGFILE_DEBUG_LOAD_EN defined: load path as above.
- Not defined:
  - LOAD_RX and LOAD_WR are absent; rx_ready and rf_write are tied to 0.
  - A load command is still accepted, goes HALT → RELEASE without writing or consuming rx bytes, and pulses done.

## Structure
- Shared header with an `ifndef` guard holds:
  - state encodings;
  - RD_OP_DUMP/RD_OP_LOAD;
  - the 32-register count constant.
- Single module; no sub-module needed. Address/remaining counters and the FSM are local.

## Test plan
- Dump first=0, count_m1=3, regs 0..3 preloaded 11,22,33,44, tx_ready=1 → tx bytes 11,22,33,44, then one done pulse; halt_req high throughout the transfers.
- Dump first=30, count_m1=3 → bytes from r30,r31,r0,r1 in that order (wrap).
- Dump with tx_ready toggling 1-of-3 cycles → tx_data stable while stalled, no byte lost or duplicated.
- Load first=16, count_m1=1, rx 0xA5,0x5A, then dump same range → r16=A5, r17=5A; rf_write_word never 1.
- halt_ack delayed 10 cycles → no rf_b change and no rf_write before ack; done only after halt_ack falls.
- Reset asserted mid-dump after 2 of 8 bytes → next cycle IDLE, tx_valid=0, halt_req=0; a new command then runs normally.
